// File: rtl/vector_pkg.sv
// ============================================================================
// Module   : vector_pkg
// Purpose  : Shared defaults, FSM state encoding and width helper for
//            the streaming dot-product engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_pkg;

  localparam int c_n_elem = 4;
  localparam int c_dw     = 4;
  localparam int c_ow     = 10;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Smallest result width that can never overflow for n_elem products of dw x dw
  function automatic int min_ow(input int n_elem, input int dw);
    return 2 * dw + $clog2(n_elem);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_mac.sv
// ============================================================================
// Module   : vector_mac
// Purpose  : Single DW x DW multiplier feeding an OW-bit accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_mac #(
  parameter int DW = 4,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [OW-1:0] o_sum
);

  logic [2*DW-1:0] w_prod;
  logic [OW-1:0]   r_acc;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
  // o_sum is the running total including the current beat, used for the final capture
  assign o_sum  = r_acc + OW'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= o_sum;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_dot_stream.sv
// ============================================================================
// Module   : vector_dot_stream
// Purpose  : Serial valid/ready dot-product engine; one element pair per beat,
//            result and element count presented on a held output stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_dot_stream
  import vector_pkg::*;
#(
  parameter int N_ELEM = c_n_elem,
  parameter int DW     = c_dw,
  parameter int OW     = c_ow
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_a,
  input  logic [DW-1:0]                 in_b,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OW-1:0]                 out_data,
  output logic [$clog2(N_ELEM+1)-1:0]   out_len
);

  localparam int            CW         = $clog2(N_ELEM + 1);
  localparam logic [CW-1:0] c_last_idx = CW'(N_ELEM - 1);

  generate
    if (OW < min_ow(N_ELEM, DW)) begin : g_ow_check
      $error("vector_dot_stream: OW too narrow for N_ELEM and DW");
    end
    if (N_ELEM < 1 || N_ELEM > 16) begin : g_n_check
      $error("vector_dot_stream: N_ELEM out of range 1..16");
    end
  endgenerate

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_final;
  logic [OW-1:0] w_sum;

  assign w_accept = in_valid && in_ready;
  assign w_final  = w_accept && (in_last || (r_cnt == c_last_idx));

  vector_mac #(
    .DW (DW),
    .OW (OW)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_final),
    .i_enable (w_accept && !w_final),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_sum    (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACC:  if (w_final)   w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_ACC;
      default: w_next = ST_ACC;
    endcase
  end

  // Handshake outputs depend on the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACC:  in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_final) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_len  <= '0;
    end else if (w_final) begin
      out_data <= w_sum;
      out_len  <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_dot_stream.sv
// ============================================================================
// Module   : tb_vector_dot_stream
// Purpose  : Self-checking bench for vector_dot_stream: vector table, corner
//            sequences and randomized vectors against a sum-of-products model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_dot_stream;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int OW = 10;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_len;

  int n_cmp = 0;
  int n_bad = 0;

  vector_dot_stream #(.N_ELEM(N), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int a[4];
    int b[4];
    int last_idx;
    int exp_d;
    int exp_l;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents one pair; returns at the negedge after the accepting edge
  task automatic put(input int a, input int b, input bit last);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("put_timeout", 0, 1);
    in_valid = 1'b1;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get(input int exp_d, input int exp_l, input int delay, input string name);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (delay) @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_data"},  int'(out_data), exp_d);
    chk({name, "_len"},   int'(out_len), exp_l);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_cleared"}, int'(out_valid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_d;
    int len;
    int a;
    int b;
    bit last;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_len",   int'(out_len), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: result valid the cycle after the final beat, input closed meanwhile
    put(1, 1, 0); put(0, 0, 0); put(0, 0, 0);
    chk("lat_not_yet", int'(out_valid), 0);
    put(1, 1, 0);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_ready_low", int'(in_ready), 0);
    get(2, 4, 0, "basic");

    // Backpressure with junk inputs offered during DONE
    put(1, 1, 0); put(2, 2, 0); put(3, 3, 0); put(0, 0, 0);
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data",  int'(out_data), 14);
      chk("bp_len",   int'(out_len), 4);
      chk("bp_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_a = 4'd1; in_b = 4'd1; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_valid", int'(out_valid), 0);
    chk("bp_rel_ready", int'(in_ready), 1);
    put(1, 1, 0); put(1, 1, 0); put(1, 1, 0); put(1, 1, 0);
    get(4, 4, 0, "bp_next");

    // Table of vectors with random idle gaps between beats
    tbl[0] = '{4, '{15, 15, 15, 15}, '{15, 15, 15, 15}, -1, 900, 4};
    tbl[1] = '{4, '{1, 1, 1, 1},     '{1, 1, 1, 1},     -1, 4,   4};
    tbl[2] = '{2, '{2, 4, 0, 0},     '{3, 5, 0, 0},      1, 26,  2};
    tbl[3] = '{4, '{1, 3, 5, 7},     '{2, 4, 6, 8},     -1, 100, 4};
    tbl[4] = '{4, '{3, 1, 0, 2},     '{3, 2, 7, 2},     -1, 15,  4};
    tbl[5] = '{1, '{7, 0, 0, 0},     '{9, 0, 0, 0},      0, 63,  1};
    tbl[6] = '{4, '{1, 1, 1, 1},     '{1, 1, 1, 1},      3, 4,   4};
    tbl[7] = '{3, '{15, 15, 15, 0},  '{15, 15, 15, 0},   2, 675, 3};
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        put(tbl[v].a[i], tbl[v].b[i], i == tbl[v].last_idx);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      get(tbl[v].exp_d, tbl[v].exp_l, 0, $sformatf("tbl%0d", v));
    end

    // Back-to-back with out_ready tied high: one result every 5 cycles
    out_ready = 1'b1; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_last = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid_t%0d", t), int'(out_valid), int'(t == 4 || t == 9));
      if (t == 4 || t == 9) chk("b2b_data", int'(out_data), 4);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Asynchronous reset mid-vector discards the partial sum
    put(5, 5, 0); put(5, 5, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data",  int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    put(1, 1, 0); put(1, 1, 0); put(1, 1, 0); put(1, 1, 0);
    get(4, 4, 0, "after_mid_rst");

    // Reset while a result is waiting
    put(2, 2, 0); put(2, 2, 0); put(2, 2, 0); put(2, 2, 0);
    chk("done_pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("done_rst_out_valid", int'(out_valid), 0);
    chk("done_rst_in_ready",  int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    put(3, 1, 0); put(1, 1, 1);
    get(4, 2, 0, "after_done_rst");

    // Random vectors against a plain sum-of-products model
    for (int v = 0; v < 40; v++) begin
      len   = $urandom_range(1, N);
      exp_d = 0;
      for (int i = 0; i < len; i++) begin
        a     = $urandom_range(0, 15);
        b     = $urandom_range(0, 15);
        exp_d = exp_d + a * b;
        last  = (i == len - 1) && ((len < N) || ($urandom_range(0, 1) == 1));
        put(a, b, last);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      get(exp_d, len, $urandom_range(0, 3), $sformatf("rnd%0d", v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
